// File: rtl/datapath_sequencer_if.sv
// Control bundle between the sum-of-squares datapath sequencer and its host/datapath.
// The slave side is the sequencer. The master side is the host that starts passes and reports Len.
interface datapath_sequencer_if;
  logic       start;
  logic [8:0] target_len;
  logic [1:0] stride_sel;
  logic [8:0] Len;
  logic       clear_Pipes;
  logic [1:0] p1_En;
  logic [3:0] s1_Muxes;
  logic [5:0] p2_En;
  logic [3:0] s2_Muxes;
  logic [1:0] p3_En;
  logic       out_En;
  logic       fireset;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, target_len, stride_sel, Len,
    input  clear_Pipes, p1_En, s1_Muxes, p2_En, s2_Muxes, p3_En,
           out_En, fireset, busy, done, err
  );

  modport slave (
    input  start, target_len, stride_sel, Len,
    output clear_Pipes, p1_En, s1_Muxes, p2_En, s2_Muxes, p3_En,
           out_En, fireset, busy, done, err
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Moore control FSM for one sum-of-squares accumulation pass: it fetches groups of three
// pointer pairs, captures six words, and accumulates three product pairs until Len meets the target.
module datapath_sequencer #(
  parameter int unsigned MAX_GROUPS = 85
) (
  input logic                  clk,
  input logic                  reset,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, F0, F1, F2, CAP, S0, S1, S2, DRAIN, CHECK, DONE
  } state_t;

  state_t      r_state, w_next;
  logic [8:0]  r_target;
  logic [1:0]  r_stride;
  logic [6:0]  r_grp;
  logic        r_err;

  logic        w_len_hit, w_grp_max;
  logic        w_clear, w_out, w_busy, w_done;
  logic [1:0]  w_p1, w_p3;
  logic [3:0]  w_s1, w_s2;
  logic [5:0]  w_p2;

  assign w_len_hit = (bus.Len >= r_target);
  assign w_grp_max = (r_grp == 7'(MAX_GROUPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_stride <= '0;
      r_grp    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.start) begin
          r_target <= bus.target_len;
          r_stride <= bus.stride_sel;
          r_grp    <= '0;
          r_err    <= 1'b0;
        end
        DRAIN: r_grp <= r_grp + 7'd1;
        CHECK: if (!w_len_hit && w_grp_max) r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? CLEAR : IDLE;
      // Len is zero once CLEAR completes, so a zero target needs no fetch at all.
      CLEAR:   w_next = (r_target == '0) ? DONE : F0;
      F0:      w_next = F1;
      F1:      w_next = F2;
      F2:      w_next = CAP;
      CAP:     w_next = S0;
      S0:      w_next = S1;
      S1:      w_next = S2;
      S2:      w_next = DRAIN;
      DRAIN:   w_next = CHECK;
      CHECK:   w_next = (w_len_hit || w_grp_max) ? DONE : F0;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_clear = 1'b0;
    w_p1    = '0;
    w_s1    = '0;
    w_p2    = '0;
    w_s2    = '0;
    w_p3    = '0;
    w_out   = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    if (r_state != IDLE) w_s1[3:2] = r_stride;
    case (r_state)
      CLEAR: begin w_clear = 1'b1; w_busy = 1'b1; end
      F0: begin
        w_p1      = 2'b11;
        w_s1[1:0] = (r_grp == '0) ? 2'b00 : 2'b11;
        w_busy    = 1'b1;
      end
      F1:    begin w_p1 = 2'b11; w_s1[1:0] = 2'b11; w_p2 = 6'b110000; w_busy = 1'b1; end
      F2:    begin w_p1 = 2'b11; w_s1[1:0] = 2'b11; w_p2 = 6'b001100; w_busy = 1'b1; end
      CAP:   begin w_p2 = 6'b000011; w_busy = 1'b1; end
      S0:    begin w_s2 = 4'b0011; w_p3 = 2'b11; w_busy = 1'b1; end
      S1:    begin w_s2 = 4'b1100; w_p3 = 2'b11; w_out = 1'b1; w_busy = 1'b1; end
      S2:    begin w_s2 = 4'b0000; w_p3 = 2'b11; w_out = 1'b1; w_busy = 1'b1; end
      DRAIN: begin w_out = 1'b1; w_busy = 1'b1; end
      CHECK: w_busy = 1'b1;
      DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.clear_Pipes = w_clear;
  assign bus.p1_En       = w_p1;
  assign bus.s1_Muxes    = w_s1;
  assign bus.p2_En       = w_p2;
  assign bus.s2_Muxes    = w_s2;
  assign bus.p3_En       = w_p3;
  assign bus.out_En      = w_out;
  assign bus.fireset     = w_out;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.err         = r_err;

endmodule
